instr_fetch: RTL and testbench

Instruction fetch stage for the 32-bit CPU, sitting between the program counter register and the decode stage. It reads the current PC and fetches the instruction at that address from instruction memory using a req/ack handshake. The fetched instruction goes to decode through a one-entry valid/ready buffer. The block also drives the PC register's control (`pc_op`, `pc_target`), so the PC advances only once an instruction has been accepted from memory, and branch redirects load the new target.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/instr_fetch.sv | 146 ++++++++++++++
 tb/tb_instr_fetch.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Definitions shared by the CPU front end.
//   XLEN          : address / instruction width
//   PC_OP_*       : PC register control encodings; the PC register decodes them too
//   fetch_state_e : state encoding of the instruction fetch FSM
// ----------------------------------------------------------------------------
package cpu_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [1:0] PC_OP_INC  = 2'b00;
   localparam logic [1:0] PC_OP_LOAD = 2'b01;
   localparam logic [1:0] PC_OP_HOLD = 2'b10;

   typedef enum logic [2:0] {
      FS_IDLE  = 3'd0,
      FS_REQ   = 3'd1,
      FS_HOLD  = 3'd2,
      FS_DRAIN = 3'd3,
      FS_STOP  = 3'd4
   } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
// Fetch stage. It reads the PC, fetches the instruction at that address over a
// req/ack memory handshake and hands it to decode through a one-entry
// valid/ready buffer. It also drives the PC register control so that the PC
// advances only after a successful fetch and loads the target on a redirect.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   pc_addr             current PC register value
//   pc_op, pc_target    PC register control (INC / LOAD / HOLD) and load value
//   imem_req/addr       memory request and registered request address
//   imem_ack/rdata/err  memory response, data and access fault
//   if_valid/ready      buffer handshake towards decode
//   if_instr/pc/fault   buffered instruction, its address, fault marker
//   redirect_valid/pc   single-cycle redirect (branch, jump, trap) and target
// ----------------------------------------------------------------------------
module instr_fetch #(
   parameter int unsigned XLEN = cpu_pkg::XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_addr,
   output logic [1:0]      pc_op,
   output logic [XLEN-1:0] pc_target,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            imem_err,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc,
   output logic            if_fault,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc
);

   import cpu_pkg::*;

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] req_addr_q, req_addr_d;
   logic            fault_pend_q, fault_pend_d;
   logic            valid_q, valid_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            fault_q, fault_d;
   logic            ack;

   // An ack only counts while a request is actually driven.
   assign imem_req  = (state_q == FS_REQ) || (state_q == FS_DRAIN);
   assign ack       = imem_req && imem_ack;
   assign imem_addr = req_addr_q;
   assign pc_target = redirect_pc;

   assign if_valid  = valid_q;
   assign if_instr  = instr_q;
   assign if_pc     = pc_q;
   assign if_fault  = fault_q;

   always_comb begin
      state_d      = state_q;
      req_addr_d   = req_addr_q;
      fault_pend_d = fault_pend_q;
      valid_d      = valid_q;
      instr_d      = instr_q;
      pc_d         = pc_q;
      fault_d      = fault_q;
      pc_op        = PC_OP_HOLD;

      if (redirect_valid) begin
         // Redirect overrides every state: flush the buffer and drop any data
         // acked this cycle. A request still waiting for its ack must be
         // drained before a new one can be issued.
         pc_op        = PC_OP_LOAD;
         valid_d      = 1'b0;
         fault_pend_d = 1'b0;
         if (((state_q == FS_REQ) && !ack) || (state_q == FS_DRAIN))
            state_d = FS_DRAIN;
         else
            state_d = FS_IDLE;
      end else begin
         case (state_q)
            FS_IDLE: begin
               state_d    = FS_REQ;
               req_addr_d = pc_addr;
            end
            FS_REQ: begin
               if (ack) begin
                  valid_d = 1'b1;
                  pc_d    = req_addr_q;
                  state_d = FS_HOLD;
                  if (imem_err) begin
                     instr_d      = '0;
                     fault_d      = 1'b1;
                     fault_pend_d = 1'b1;
                  end else begin
                     instr_d = imem_rdata;
                     fault_d = 1'b0;
                     pc_op   = PC_OP_INC;
                  end
               end
            end
            FS_HOLD: begin
               if (if_ready) begin
                  valid_d    = 1'b0;
                  req_addr_d = pc_addr;
                  state_d    = fault_pend_q ? FS_STOP : FS_REQ;
               end
            end
            FS_DRAIN: begin
               if (ack)
                  state_d = FS_IDLE;
            end
            FS_STOP: begin
               state_d = FS_STOP;
            end
            default: begin
               state_d = FS_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= FS_IDLE;
         req_addr_q   <= '0;
         fault_pend_q <= 1'b0;
         valid_q      <= 1'b0;
         instr_q      <= '0;
         pc_q         <= '0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_addr_q   <= req_addr_d;
         fault_pend_q <= fault_pend_d;
         valid_q      <= valid_d;
         instr_q      <= instr_d;
         pc_q         <= pc_d;
         fault_q      <= fault_d;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch
// Directed bench for instr_fetch. A small PC register model closes the loop
// on pc_op/pc_target; memory responses are driven step by step.
// ----------------------------------------------------------------------------
module tb_instr_fetch;

   logic        clk;
   logic        rst;
   logic [31:0] pc;
   logic [1:0]  pc_op;
   logic [31:0] pc_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        imem_err;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_fault;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   int errs   = 0;
   int checks = 0;

   instr_fetch #(.XLEN(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .pc_addr        (pc),
      .pc_op          (pc_op),
      .pc_target      (pc_target),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .imem_err       (imem_err),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_fault       (if_fault),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // PC register as seen by the fetch stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  pc <= '0;
      else if (pc_op == 2'b00)  pc <= pc + 32'd4;
      else if (pc_op == 2'b01)  pc <= pc_target;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change 2 time units after the edge, checks at +3.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; imem_err = 1'b0;
      if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
      #1;
      chk("rst_req",    {31'd0, imem_req}, 32'd0);
      chk("rst_addr",   imem_addr, 32'd0);
      chk("rst_valid",  {31'd0, if_valid}, 32'd0);
      chk("rst_instr",  if_instr, 32'd0);
      chk("rst_ifpc",   if_pc, 32'd0);
      chk("rst_fault",  {31'd0, if_fault}, 32'd0);
      chk("rst_pcop",   {30'd0, pc_op}, 32'd2);
      chk("rst_target", pc_target, 32'd0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;

      // IDLE
      #1 chk("idle_pcop", {30'd0, pc_op}, 32'd2);
      chk("idle_req", {31'd0, imem_req}, 32'd0);
      step();
      // REQ to 0, acked same cycle
      imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
      #1 chk("req0_req", {31'd0, imem_req}, 32'd1);
      chk("req0_addr", imem_addr, 32'h0);
      chk("req0_pcop", {30'd0, pc_op}, 32'd0);
      step();
      // HOLD, consumed at once
      imem_ack = 1'b0;
      #1 chk("h0_valid", {31'd0, if_valid}, 32'd1);
      chk("h0_instr", if_instr, 32'h0050_0093);
      chk("h0_ifpc",  if_pc, 32'h0);
      chk("h0_fault", {31'd0, if_fault}, 32'd0);
      chk("h0_pc",    pc, 32'h4);
      chk("h0_pcop",  {30'd0, pc_op}, 32'd2);
      step();

      // REQ to 4, ack three cycles late
      for (int i = 0; i < 3; i++) begin
         #1 chk("late_req",  {31'd0, imem_req}, 32'd1);
         chk("late_addr",  imem_addr, 32'h4);
         chk("late_pcop",  {30'd0, pc_op}, 32'd2);
         chk("late_valid", {31'd0, if_valid}, 32'd0);
         step();
      end
      imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
      #1 chk("late_ack_req",  {31'd0, imem_req}, 32'd1);
      chk("late_ack_addr", imem_addr, 32'h4);
      chk("late_ack_pcop", {30'd0, pc_op}, 32'd0);
      step();

      // HOLD with decode stalled for five cycles
      imem_ack = 1'b0; if_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1 chk("stall_valid", {31'd0, if_valid}, 32'd1);
         chk("stall_instr", if_instr, 32'h1111_1111);
         chk("stall_ifpc",  if_pc, 32'h4);
         chk("stall_req",   {31'd0, imem_req}, 32'd0);
         chk("stall_pcop",  {30'd0, pc_op}, 32'd2);
         chk("stall_pc",    pc, 32'h8);
         step();
      end
      if_ready = 1'b1;
      #1 chk("stall_end_valid", {31'd0, if_valid}, 32'd1);
      step();

      // REQ to 8 outstanding, redirect to 0x100, ack two cycles after it
      #1 chk("rd_req",  {31'd0, imem_req}, 32'd1);
      chk("rd_addr", imem_addr, 32'h8);
      step();
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      #1 chk("rd_pcop",   {30'd0, pc_op}, 32'd1);
      chk("rd_target", pc_target, 32'h100);
      step();
      redirect_valid = 1'b0;
      #1 chk("drain_req",   {31'd0, imem_req}, 32'd1);
      chk("drain_addr",  imem_addr, 32'h8);
      chk("drain_pcop",  {30'd0, pc_op}, 32'd2);
      chk("drain_valid", {31'd0, if_valid}, 32'd0);
      chk("drain_pc",    pc, 32'h100);
      step();
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      #1 chk("drain_ack_pcop", {30'd0, pc_op}, 32'd2);
      step();
      imem_ack = 1'b0;
      #1 chk("post_drain_req",   {31'd0, imem_req}, 32'd0);
      chk("post_drain_valid", {31'd0, if_valid}, 32'd0);
      chk("post_drain_pc",    pc, 32'h100);
      step();
      imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
      #1 chk("r100_req",  {31'd0, imem_req}, 32'd1);
      chk("r100_addr", imem_addr, 32'h100);
      chk("r100_pcop", {30'd0, pc_op}, 32'd0);
      step();

      // HOLD at 0x100, redirect to 0x20 suppresses the handshake
      imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h20;
      #1 chk("h100_ifpc",  if_pc, 32'h100);
      chk("h100_instr", if_instr, 32'h2222_2222);
      chk("h100_pcop",  {30'd0, pc_op}, 32'd1);
      step();
      redirect_valid = 1'b0;
      #1 chk("i20_valid", {31'd0, if_valid}, 32'd0);
      chk("i20_req",   {31'd0, imem_req}, 32'd0);
      chk("i20_pc",    pc, 32'h20);
      step();

      // REQ to 0x20 faults
      imem_ack = 1'b1; imem_err = 1'b1; imem_rdata = 32'h3333_3333;
      #1 chk("f_req",  {31'd0, imem_req}, 32'd1);
      chk("f_addr", imem_addr, 32'h20);
      chk("f_pcop", {30'd0, pc_op}, 32'd2);
      step();
      imem_ack = 1'b0; imem_err = 1'b0;
      #1 chk("f_valid", {31'd0, if_valid}, 32'd1);
      chk("f_fault", {31'd0, if_fault}, 32'd1);
      chk("f_instr", if_instr, 32'h0);
      chk("f_ifpc",  if_pc, 32'h20);
      chk("f_pc",    pc, 32'h20);
      step();
      for (int i = 0; i < 2; i++) begin
         #1 chk("stop_req",   {31'd0, imem_req}, 32'd0);
         chk("stop_valid", {31'd0, if_valid}, 32'd0);
         chk("stop_pcop",  {30'd0, pc_op}, 32'd2);
         step();
      end
      redirect_valid = 1'b1; redirect_pc = 32'h40;
      #1 chk("stop_rd_pcop",   {30'd0, pc_op}, 32'd1);
      chk("stop_rd_target", pc_target, 32'h40);
      step();
      redirect_valid = 1'b0;
      #1 chk("i40_req", {31'd0, imem_req}, 32'd0);
      step();
      #1 chk("r40_req",  {31'd0, imem_req}, 32'd1);
      chk("r40_addr", imem_addr, 32'h40);
      chk("r40_pc",   pc, 32'h40);

      // Reset while the request to 0x40 is outstanding
      redirect_pc = 32'h0;
      rst = 1'b1;
      #1 chk("mr_req",   {31'd0, imem_req}, 32'd0);
      chk("mr_addr",  imem_addr, 32'h0);
      chk("mr_valid", {31'd0, if_valid}, 32'd0);
      chk("mr_instr", if_instr, 32'h0);
      chk("mr_ifpc",  if_pc, 32'h0);
      chk("mr_fault", {31'd0, if_fault}, 32'd0);
      chk("mr_pcop",  {30'd0, pc_op}, 32'd2);
      chk("mr_target", pc_target, 32'h0);
      chk("mr_pc",    pc, 32'h0);
      step();
      rst = 1'b0;
      #1 chk("mr_idle_req", {31'd0, imem_req}, 32'd0);
      step();
      #1 chk("mr_restart_req",  {31'd0, imem_req}, 32'd1);
      chk("mr_restart_addr", imem_addr, 32'h0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
